cmac_usplus_absorber: RTL

Receive-side companion to the CMAC TX emitter path: accepts the 512-bit segmented RX stream (sop/eop/mty) from the CMAC user interface, writes each beat of one frame into a downstream frame buffer at consecutive addresses, and counts the frame length in bytes. On end of frame it presents length and error status to the consumer and holds them until acknowledged. Frames arriving while the previous frame is unacknowledged, oversize frames and truncated frames are discarded.

---
 rtl/cmac_usplus_absorber.sv | 122 ++++++++++++
 1 files changed

// File: rtl/cmac_usplus_absorber.sv
// CMAC RX absorber: writes each frame's beats into a frame buffer, measures its byte length,
// and holds length/error until acknowledged. Optional macro CMAC_RX_ABSORBER_STATS_EN.
module cmac_usplus_absorber #(
  parameter int unsigned MAX_BEATS = 150,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [511:0]      din_data,
  input  logic              din_valid,
  input  logic              din_sop,
  input  logic              din_eop,
  input  logic [7:0]        din_mty,
  input  logic              din_err,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [511:0]      wr_data,
  output logic              frame_valid,
  output logic [13:0]       frame_bytes,
  output logic              frame_err,
  input  logic              frame_ack,
  output logic [15:0]       drop_count
);

  localparam int unsigned CntW = ADDR_W + 1;

  typedef enum logic [2:0] {StIdle, StRecv, StDrop, StHold, StHoldDrop} state_e;

  state_e          state_q;
  logic [CntW-1:0] beat_cnt_q;
  logic [13:0]     acc_q;

  logic [13:0] beat_bytes;
  logic        in_hold, start_new, cont, over, hold_drop, drop_inc, complete;

  always_comb begin
    beat_bytes = din_eop ? (14'd64 - {8'd0, din_mty[5:0]}) : 14'd64;
    in_hold    = (state_q == StHold) || (state_q == StHoldDrop);
    // While a frame is held, a new sop is only taken if the consumer releases it this cycle.
    start_new  = din_valid && din_sop && (!in_hold || frame_ack);
    cont       = din_valid && !din_sop && (state_q == StRecv) && (beat_cnt_q < CntW'(MAX_BEATS));
    over       = din_valid && !din_sop && (state_q == StRecv) && (beat_cnt_q >= CntW'(MAX_BEATS));
    hold_drop  = din_valid && din_sop && in_hold && !frame_ack;
    drop_inc   = over || hold_drop || (din_valid && din_sop && (state_q == StRecv));
    complete   = (start_new || cont) && din_eop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      beat_cnt_q  <= '0;
      acc_q       <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_valid <= 1'b0;
      frame_bytes <= '0;
      frame_err   <= 1'b0;
    end else begin
      wr_en <= start_new || cont;
      if (start_new || cont) begin
        wr_data <= din_data;
        wr_addr <= start_new ? '0 : beat_cnt_q[ADDR_W-1:0];
      end
      if (start_new) begin
        beat_cnt_q <= CntW'(1);
        acc_q      <= beat_bytes;
      end else if (cont) begin
        beat_cnt_q <= beat_cnt_q + CntW'(1);
        acc_q      <= acc_q + beat_bytes;
      end

      if (complete) begin
        frame_valid <= 1'b1;
        frame_bytes <= start_new ? beat_bytes : (acc_q + beat_bytes);
        frame_err   <= din_err;
      end else if (frame_ack && frame_valid) begin
        frame_valid <= 1'b0;
      end

      if (start_new) begin
        state_q <= din_eop ? StHold : StRecv;
      end else begin
        case (state_q)
          StRecv: begin
            if (cont)      state_q <= din_eop ? StHold : StRecv;
            else if (over) state_q <= din_eop ? StIdle : StDrop;
          end
          StDrop: begin
            if (din_valid && din_eop) state_q <= StIdle;
          end
          StHold: begin
            if (hold_drop)      state_q <= din_eop ? StHold : StHoldDrop;
            else if (frame_ack) state_q <= StIdle;
          end
          StHoldDrop: begin
            // Released mid-discard: keep discarding the unwanted frame without holding.
            if (hold_drop)                 state_q <= din_eop ? StHold : StHoldDrop;
            else if (din_valid && din_eop) state_q <= frame_ack ? StIdle : StHold;
            else if (frame_ack)            state_q <= StDrop;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

`ifdef CMAC_RX_ABSORBER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop_inc && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop_inc;
  assign drop_count  = '0;
`endif

endmodule
